// File: rtl/reset_pulse_gen_pkg.sv
// Shared types and constants for the board-level reset request generator.
package reset_pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } state_e;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_BTN = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;
  localparam logic [1:0] CAUSE_WDT = 2'b11;

  localparam int RST_CNT_W = 8;

  function automatic logic [RST_CNT_W-1:0] sat_inc(input logic [RST_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/reset_pulse_gen_if.sv
// Request inputs and status outputs of reset_pulse_gen, grouped as one bundle.
interface reset_pulse_gen_if;
  import reset_pulse_gen_pkg::*;

  logic                 BTN_I;
  logic                 SW_REQ_I;
  logic                 WDT_KICK_I;
  logic                 RST_O;
  logic                 BUSY_O;
  logic [1:0]           CAUSE_O;
  logic [RST_CNT_W-1:0] RST_CNT_O;

  modport master (
    output BTN_I, SW_REQ_I, WDT_KICK_I,
    input  RST_O, BUSY_O, CAUSE_O, RST_CNT_O
  );

  modport slave (
    input  BTN_I, SW_REQ_I, WDT_KICK_I,
    output RST_O, BUSY_O, CAUSE_O, RST_CNT_O
  );

endinterface

// File: rtl/reset_pulse_gen_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, and a
// one-cycle pulse on each accepted 0->1 change of the debounced level.
module rst_debounce #(
  parameter int DEBOUNCE_LEN = 1024
) (
  input  logic CLK_I,
  input  logic RSTN_I,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int DB_W = (DEBOUNCE_LEN > 1) ? $clog2(DEBOUNCE_LEN) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_LEN - 1);

  logic [1:0]      sync_q;
  logic            btn_s;
  logic            level_q, level_d;
  logic            rise_q, rise_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  assign btn_s = sync_q[1];

  // The counter only advances while the synchronised input disagrees with the
  // accepted level, so any bounce back clears it.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path
    // that leaves one unassigned would infer a latch.
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (btn_s != level_q) begin
      if (cnt_q == DB_LAST) begin
        level_d = btn_s;
        rise_d  = btn_s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values, independent of statement order.
      sync_q  <= {sync_q[0], raw_i};
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/reset_pulse_gen.sv
// Board-level reset request generator: fixed-width RST_O pulse plus hold-off,
// with cause and event count. Watchdog source enabled by RESET_PULSE_GEN_WATCHDOG_EN.
module reset_pulse_gen
  import reset_pulse_gen_pkg::*;
#(
  parameter int PULSE_LEN    = 16,
  parameter int HOLDOFF_LEN  = 64,
  parameter int DEBOUNCE_LEN = 1024,
  parameter int WDT_TIMEOUT  = 65536
) (
  input  logic             CLK_I,
  input  logic             RSTN_I,
  reset_pulse_gen_if.slave bus
);

  localparam int CNT_LEN = (PULSE_LEN > HOLDOFF_LEN) ? PULSE_LEN : HOLDOFF_LEN;
  localparam int CNT_W   = (CNT_LEN > 1) ? $clog2(CNT_LEN) : 1;
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_LEN - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           cause_q, cause_d;
  logic [RST_CNT_W-1:0] rst_cnt_q, rst_cnt_d;
  logic                 rst_q, rst_d;
  logic                 busy_q, busy_d;

  logic                 btn_level;
  logic                 btn_rise;
  logic                 wdt_req;
  logic                 req_any;
  logic [1:0]           req_cause;

  rst_debounce #(
    .DEBOUNCE_LEN(DEBOUNCE_LEN)
  ) u_debounce (
    .CLK_I  (CLK_I),
    .RSTN_I (RSTN_I),
    .raw_i  (bus.BTN_I),
    .level_o(btn_level),
    .rise_o (btn_rise)
  );

`ifdef RESET_PULSE_GEN_WATCHDOG_EN
  localparam int WDT_W = (WDT_TIMEOUT > 1) ? $clog2(WDT_TIMEOUT) : 1;
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_TIMEOUT - 1);

  logic [WDT_W-1:0] wdt_q, wdt_d;

  // A kick on the terminal-count cycle takes precedence over the timeout.
  always_comb begin
    wdt_d   = wdt_q + 1'b1;
    wdt_req = 1'b0;
    if (state_q != IDLE || bus.WDT_KICK_I) begin
      wdt_d = '0;
    end else if (wdt_q == WDT_LAST) begin
      wdt_d   = '0;
      wdt_req = 1'b1;
    end
  end

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) wdt_q <= '0;
    else         wdt_q <= wdt_d;
  end
`else
  logic unused_wdt_kick;
  assign unused_wdt_kick = bus.WDT_KICK_I;
  assign wdt_req         = 1'b0;
`endif

  logic unused_btn_level;
  assign unused_btn_level = btn_level;

  assign req_any = wdt_req | btn_rise | bus.SW_REQ_I;

  always_comb begin
    if (wdt_req)       req_cause = CAUSE_WDT;
    else if (btn_rise) req_cause = CAUSE_BTN;
    else               req_cause = CAUSE_SW;
  end

  // Requests are only looked at in IDLE; elsewhere they fall on the floor.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cause_d   = cause_q;
    rst_cnt_d = rst_cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_any) begin
          state_d   = ASSERT;
          cause_d   = req_cause;
          rst_cnt_d = sat_inc(rst_cnt_q);
        end
      end
      ASSERT: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = HOLDOFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLDOFF: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ASSERT;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so RST_O rises on the same
  // edge that accepts the request.
  assign rst_d  = (state_d == ASSERT);
  assign busy_d = (state_d != IDLE);

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      state_q   <= ASSERT;
      cnt_q     <= '0;
      cause_q   <= CAUSE_POR;
      rst_cnt_q <= '0;
      rst_q     <= 1'b1;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cause_q   <= cause_d;
      rst_cnt_q <= rst_cnt_d;
      rst_q     <= rst_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.RST_O     = rst_q;
  assign bus.BUSY_O    = busy_q;
  assign bus.CAUSE_O   = cause_q;
  assign bus.RST_CNT_O = rst_cnt_q;

endmodule

// File: tb/tb_reset_pulse_gen.sv
// Directed bench for reset_pulse_gen with PULSE_LEN=4, HOLDOFF_LEN=8,
// DEBOUNCE_LEN=16, WDT_TIMEOUT=64; watchdog steps need RESET_PULSE_GEN_WATCHDOG_EN.
module tb_reset_pulse_gen;
  import reset_pulse_gen_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   pulses = 0;
  logic rst_prev = 1'b0;

  always #5 clk = ~clk;

  reset_pulse_gen_if bus ();

  reset_pulse_gen #(
    .PULSE_LEN   (4),
    .HOLDOFF_LEN (8),
    .DEBOUNCE_LEN(16),
    .WDT_TIMEOUT (64)
  ) dut (
    .CLK_I (clk),
    .RSTN_I(rst_n),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges, sampling 1 time unit after each edge and counting
  // rising edges of RST_O.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (bus.RST_O === 1'b1 && rst_prev !== 1'b1) pulses++;
      rst_prev = bus.RST_O;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.BUSY_O !== 1'b0 && n < 100) begin
      step();
      n++;
    end
    check("idle_reached", {7'd0, bus.BUSY_O}, 8'd0);
  endtask

  initial begin
    bus.BTN_I      = 1'b0;
    bus.SW_REQ_I   = 1'b0;
    bus.WDT_KICK_I = 1'b1;

    // 1. Power-on reset and POR pulse
    rst_n = 1'b0;
    step(3);
    check("por_rst",   {7'd0, bus.RST_O},  8'd1);
    check("por_busy",  {7'd0, bus.BUSY_O}, 8'd1);
    check("por_cause", {6'd0, bus.CAUSE_O}, {6'd0, CAUSE_POR});
    check("por_cnt",   bus.RST_CNT_O, 8'd0);
    rst_n = 1'b1;
    step();
    check("por_pulse_1", {7'd0, bus.RST_O}, 8'd1);
    step(2);
    check("por_pulse_3", {7'd0, bus.RST_O}, 8'd1);
    step();
    check("por_pulse_end", {7'd0, bus.RST_O},  8'd0);
    check("por_hold_busy", {7'd0, bus.BUSY_O}, 8'd1);
    step(7);
    check("por_hold_11", {7'd0, bus.BUSY_O}, 8'd1);
    step();
    check("por_idle_12", {7'd0, bus.BUSY_O}, 8'd0);
    check("por_cause_after", {6'd0, bus.CAUSE_O}, {6'd0, CAUSE_POR});

    // 2. Software request, then one dropped during hold-off
    step(2);
    bus.SW_REQ_I = 1'b1;
    step();
    bus.SW_REQ_I = 1'b0;
    check("sw_rst_k1", {7'd0, bus.RST_O}, 8'd1);
    check("sw_cause",  {6'd0, bus.CAUSE_O}, {6'd0, CAUSE_SW});
    check("sw_cnt",    bus.RST_CNT_O, 8'd1);
    step(3);
    check("sw_rst_k4", {7'd0, bus.RST_O}, 8'd1);
    step();
    check("sw_rst_end", {7'd0, bus.RST_O}, 8'd0);
    step();
    bus.SW_REQ_I = 1'b1;
    step();
    bus.SW_REQ_I = 1'b0;
    check("sw_holdoff_drop_rst", {7'd0, bus.RST_O}, 8'd0);
    check("sw_holdoff_drop_cnt", bus.RST_CNT_O, 8'd1);
    wait_idle();

    // 3. Bouncing button, then a held press, then release
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      bus.BTN_I = (i % 2 == 0);
      step(3);
    end
    check("bounce_no_reset", pulses[7:0], 8'd0);
    bus.BTN_I = 1'b1;
    step(40);
    check("btn_one_reset", pulses[7:0], 8'd1);
    check("btn_cause", {6'd0, bus.CAUSE_O}, {6'd0, CAUSE_BTN});
    check("btn_cnt",   bus.RST_CNT_O, 8'd2);
    bus.BTN_I = 1'b0;
    step(40);
    check("btn_release_none", pulses[7:0], 8'd1);
    check("btn_release_cnt",  bus.RST_CNT_O, 8'd2);

    // 4. Debounced button edge and software request on the same edge
    bus.BTN_I = 1'b1;
    step(18);
    check("tie_no_early", {7'd0, bus.RST_O}, 8'd0);
    bus.SW_REQ_I = 1'b1;
    step();
    bus.SW_REQ_I = 1'b0;
    check("tie_rst",   {7'd0, bus.RST_O}, 8'd1);
    check("tie_cause", {6'd0, bus.CAUSE_O}, {6'd0, CAUSE_BTN});
    check("tie_cnt",   bus.RST_CNT_O, 8'd3);
    wait_idle();
    bus.BTN_I = 1'b0;
    step(30);
    check("tie_cnt_after", bus.RST_CNT_O, 8'd3);

`ifdef RESET_PULSE_GEN_WATCHDOG_EN
    // 5. Watchdog timeout, kick on terminal count, periodic kicks
    bus.WDT_KICK_I = 1'b0;
    step(63);
    check("wdt_pre_timeout", {7'd0, bus.RST_O}, 8'd0);
    step();
    check("wdt_timeout_rst", {7'd0, bus.RST_O}, 8'd1);
    check("wdt_cause", {6'd0, bus.CAUSE_O}, {6'd0, CAUSE_WDT});
    check("wdt_cnt",   bus.RST_CNT_O, 8'd4);
    wait_idle();
    step(63);
    bus.WDT_KICK_I = 1'b1;
    step();
    bus.WDT_KICK_I = 1'b0;
    check("wdt_kick_wins", {7'd0, bus.RST_O}, 8'd0);
    pulses = 0;
    repeat (10) begin
      bus.WDT_KICK_I = 1'b1;
      step();
      bus.WDT_KICK_I = 1'b0;
      step(49);
    end
    check("wdt_kicked_none", pulses[7:0], 8'd0);
    check("wdt_kicked_cnt",  bus.RST_CNT_O, 8'd4);
    bus.WDT_KICK_I = 1'b1;
`endif

    // 6. Reset asserted in the middle of a pulse
    bus.SW_REQ_I = 1'b1;
    step();
    bus.SW_REQ_I = 1'b0;
    check("mid_rst_pulse", {7'd0, bus.RST_O}, 8'd1);
    step(2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_o",     {7'd0, bus.RST_O},  8'd1);
    check("mid_rst_busy",  {7'd0, bus.BUSY_O}, 8'd1);
    check("mid_rst_cause", {6'd0, bus.CAUSE_O}, {6'd0, CAUSE_POR});
    check("mid_rst_cnt",   bus.RST_CNT_O, 8'd0);
    step(2);
    rst_n = 1'b1;
    step(3);
    check("mid_por_pulse_3", {7'd0, bus.RST_O}, 8'd1);
    step();
    check("mid_por_pulse_end", {7'd0, bus.RST_O}, 8'd0);
    check("mid_por_cnt", bus.RST_CNT_O, 8'd0);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
